// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt priority controller.
// Optional feature macro used by this slice: IRQ_ROUND_ROBIN_EN (rotating priority).
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int N_IRQ_DEF = 8;

    // Ceiling log2, used to size the interrupt index.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Combinational priority picker.
// Searches downward from base (base, base-1, ..., 0, N_IRQ-1, ..., base+1) and
// reports the first set bit. With base = N_IRQ-1 this is plain fixed priority,
// highest index wins.
module irq_prio_pick
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W  = clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] vec,
    input  logic [ID_W-1:0]  base,
    output logic             valid,
    output logic [ID_W-1:0]  idx
);

    int p;

    // First set bit in rotated descending order wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        p     = 0;
        for (int i = 0; i < N_IRQ; i++) begin
            p = int'(base) - i;
            if (p < 0) p = p + N_IRQ;
            if (!valid && vec[p[ID_W-1:0]]) begin
                valid = 1'b1;
                idx   = p[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/irq_priority_ctrl.sv
// 8-input interrupt controller: rising-edge capture into a pending register,
// masking, priority selection, req/ack handshake to the CPU and in-service
// tracking until EOI. Outputs are registered.
// Macro IRQ_ROUND_ROBIN_EN: when defined, priority rotates past the last
// acknowledged line; when undefined, fixed priority with highest index first.
module irq_priority_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W  = clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    input  logic             irq_ack,
    input  logic             eoi,
    output logic             irq_req,
    output logic [ID_W-1:0]  irq_id,
    output logic             busy,
    output logic [N_IRQ-1:0] pending
);

    state_t            state_q, state_d;
    logic [N_IRQ-1:0]  irq_prev;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  eligible;
    logic [N_IRQ-1:0]  pending_d;
    logic              req_d, busy_d, clr;
    logic [ID_W-1:0]   id_d;
    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   base;

    assign rise     = irq_in & ~irq_prev;
    // Masked lines stay latched but can never be chosen.
    assign eligible = pending & ~mask;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_base;

    // After acking line k the search starts at k-1, so k drops to last place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_base <= ID_W'(N_IRQ - 1);
        else if (clr)
            rr_base <= (irq_id == '0) ? ID_W'(N_IRQ - 1) : irq_id - 1'b1;
    end

    assign base = rr_base;
`else
    assign base = ID_W'(N_IRQ - 1);
`endif

    irq_prio_pick #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_pick (
        .vec   (eligible),
        .base  (base),
        .valid (pick_valid),
        .idx   (pick_id)
    );

    // Handshake FSM: next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        req_d   = irq_req;
        id_d    = irq_id;
        busy_d  = busy;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = pick_id;
                end
            end
            REQ: begin
                // Request is neither preempted nor retracted; only ack moves on.
                if (irq_ack) begin
                    state_d = SERVICE;
                    req_d   = 1'b0;
                    busy_d  = 1'b1;
                    clr     = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending update: ack clears the served bit, a new edge in the same cycle sets it again.
    always_comb begin
        pending_d = pending;
        if (clr) pending_d[irq_id] = 1'b0;
        pending_d = pending_d | rise;
    end

    // State, edge history, pending and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            irq_prev <= '0;
            pending  <= '0;
            irq_req  <= 1'b0;
            irq_id   <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_prev <= irq_in;
            pending  <= pending_d;
            irq_req  <= req_d;
            irq_id   <= id_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: reset, single event, simultaneous
// events, masking, reset in service and priority order (fixed or rotating).
module tb_irq_priority_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       eoi;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    irq_priority_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .mask    (mask),
        .irq_ack (irq_ack),
        .eoi     (eoi),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .busy    (busy),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic req_e, input logic [2:0] id_e,
                             input logic busy_e, input logic [7:0] pend_e);
        check({tag, ".req"},  {31'd0, irq_req}, {31'd0, req_e});
        check({tag, ".id"},   {29'd0, irq_id},  {29'd0, id_e});
        check({tag, ".busy"}, {31'd0, busy},    {31'd0, busy_e});
        check({tag, ".pend"}, {24'd0, pending}, {24'd0, pend_e});
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        irq_in  = 8'h00;
        mask    = 8'h00;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Test 1: reset with all lines high
        rst_n   = 1'b0;
        irq_in  = 8'hFF;
        mask    = 8'h00;
        irq_ack = 1'b0;
        eoi     = 1'b0;
        step();
        step();
        check_all("rst", 1'b0, 3'd0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step();
        check_all("rel1", 1'b0, 3'd0, 1'b0, 8'hFF);
        step();
        check_all("rel2", 1'b1, 3'd7, 1'b0, 8'hFF);

        // Test 2: single event on line 3, no preemption by line 7
        do_reset();
        irq_in = 8'h08;
        step();
        check_all("s.cap", 1'b0, 3'd0, 1'b0, 8'h08);
        step();
        check_all("s.req", 1'b1, 3'd3, 1'b0, 8'h08);
        irq_in = 8'h88;
        step();
        check_all("s.nopre", 1'b1, 3'd3, 1'b0, 8'h88);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("s.ack", 1'b0, 3'd3, 1'b1, 8'h80);
        step();
        check_all("s.hold", 1'b0, 3'd3, 1'b1, 8'h80);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check_all("s.eoi", 1'b0, 3'd3, 1'b0, 8'h80);
        step();
        check_all("s.next", 1'b1, 3'd7, 1'b0, 8'h80);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 8'h00;
        step();
        check_all("s.idle", 1'b0, 3'd7, 1'b0, 8'h00);

        // Test 3: lines 2 and 5 together, ack+eoi same cycle, set-wins
        irq_in = 8'h24;
        step();
        check_all("m.cap", 1'b0, 3'd7, 1'b0, 8'h24);
        step();
        check_all("m.req5", 1'b1, 3'd5, 1'b0, 8'h24);
        irq_ack = 1'b1;
        eoi = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b0;
        check_all("m.ackeoi", 1'b0, 3'd5, 1'b1, 8'h04);
        step();
        check_all("m.still", 1'b0, 3'd5, 1'b1, 8'h04);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check_all("m.eoi", 1'b0, 3'd5, 1'b0, 8'h04);
        step();
        check_all("m.req2", 1'b1, 3'd2, 1'b0, 8'h04);
        irq_in = 8'h00;
        step();
        irq_in = 8'h04;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("m.setwin", 1'b0, 3'd2, 1'b1, 8'h04);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        check_all("m.again", 1'b1, 3'd2, 1'b0, 8'h04);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 8'h00;
        step();

        // Test 4: mask line 5, line 1 served, then unmask
        mask = 8'h20;
        irq_in = 8'h22;
        step();
        check_all("k.cap", 1'b0, 3'd2, 1'b0, 8'h22);
        step();
        check_all("k.req1", 1'b1, 3'd1, 1'b0, 8'h22);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check_all("k.ack", 1'b0, 3'd1, 1'b1, 8'h20);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        check_all("k.eoi", 1'b0, 3'd1, 1'b0, 8'h20);
        step();
        check_all("k.masked", 1'b0, 3'd1, 1'b0, 8'h20);
        mask = 8'h00;
        step();
        step();
        check_all("k.req5", 1'b1, 3'd5, 1'b0, 8'h20);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        irq_in = 8'h00;
        step();

        // Test 5: reset while in service with pending = 0C
        irq_in = 8'h08;
        step();
        step();
        check_all("r.req3", 1'b1, 3'd3, 1'b0, 8'h08);
        irq_in = 8'h00;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_in = 8'h0C;
        step();
        check_all("r.svc", 1'b0, 3'd3, 1'b1, 8'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("r.async", 1'b0, 3'd0, 1'b0, 8'h00);

        // Test 6: priority order after serving line 7
        do_reset();
        irq_in = 8'h80;
        step();
        step();
        check_all("p.req7", 1'b1, 3'd7, 1'b0, 8'h80);
        irq_in = 8'h00;
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        irq_in = 8'h84;
        step();
        check_all("p.both", 1'b0, 3'd7, 1'b1, 8'h84);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
`ifdef IRQ_ROUND_ROBIN_EN
        check_all("p.first", 1'b1, 3'd2, 1'b0, 8'h84);
`else
        check_all("p.first", 1'b1, 3'd7, 1'b0, 8'h84);
`endif
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
`ifdef IRQ_ROUND_ROBIN_EN
        check_all("p.second", 1'b1, 3'd7, 1'b0, 8'h80);
`else
        check_all("p.second", 1'b1, 3'd2, 1'b0, 8'h04);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
